// File: rtl/bram_rd_stream.sv
// bram_rd_stream: read-side streaming engine for a single-clock block RAM.
// Takes a (start address, length) command, issues one read per cycle on a RAM
// port while output credit allows, re-times the returned words through a
// small show-ahead FIFO and presents them as a valid/ready stream with last.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_addr, cmd_len     first word address, word count (0 = no-op)
//   ram_addr              registered read address to the RAM port
//   ram_dout              RAM read data, LATENCY clocks after ram_addr
//   m_data/m_valid/m_ready/m_last   output stream
//   busy                  command accepted and last word not yet popped
module bram_rd_stream #(
  parameter int DATA    = 72,
  parameter int ADDR    = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR-1:0]   cmd_addr,
  input  logic [ADDR:0]     cmd_len,
  output logic [ADDR-1:0]   ram_addr,
  input  logic [DATA-1:0]   ram_dout,
  output logic [DATA-1:0]   m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam int D  = LATENCY + 2;
  localparam int PW = $clog2(D);
  localparam int OW = $clog2(D + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR:0]   LEN_ONE  = 1;
  localparam logic [ADDR-1:0] ADDR_ONE = 1;
  localparam logic [OW-1:0]   OCC_ONE  = 1;
  localparam logic [OW-1:0]   OCC_MAX  = OW'(D);
  localparam logic [PW-1:0]   PTR_ONE  = 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(D - 1);

  logic [1:0]          state;
  logic [ADDR-1:0]     addr_cnt;
  logic [ADDR:0]       rem_cnt;
  // Stage 0 lines up with the ram_addr register, stages 1..LATENCY with the
  // RAM's internal pipeline, so stage LATENCY flags valid data on ram_dout.
  logic [LATENCY:0]    vld_pipe;
  logic [LATENCY:0]    last_pipe;
  logic [D-1:0][DATA-1:0] fifo_data;
  logic [D-1:0]        fifo_last;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [OW-1:0]       fcnt;
  // Reads in flight plus words held in the FIFO.
  logic [OW-1:0]       occ;

  logic            accept, start, pop, push, credit, issue_run, issue, issue_last;
  logic [ADDR-1:0] issue_addr;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  // The accepting edge already issues the first read, which is what makes
  // command-to-first-beat LATENCY+1 clocks.
  assign start     = accept & (cmd_len != '0);
  assign m_valid   = (fcnt != '0);
  assign m_data    = fifo_data[rd_ptr];
  assign m_last    = fifo_last[rd_ptr];
  assign pop       = m_valid & m_ready;
  assign push      = vld_pipe[LATENCY];
  // A pop this cycle frees a slot, so a full budget still issues when draining.
  assign credit    = (occ < OCC_MAX) | pop;
  assign issue_run = (state == S_ISSUE) & credit;
  assign issue     = start | issue_run;
  assign issue_addr = start ? cmd_addr : addr_cnt;
  assign issue_last = start ? (cmd_len == LEN_ONE) : (rem_cnt == LEN_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      rem_cnt   <= '0;
      ram_addr  <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state <= issue_last ? S_DRAIN : S_ISSUE;
        S_ISSUE: if (issue_run && issue_last) state <= S_DRAIN;
        S_DRAIN: if (pop && m_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (issue) begin
        ram_addr <= issue_addr;
        addr_cnt <= issue_addr + ADDR_ONE;   // wraps mod 2**ADDR
      end
      if (start)          rem_cnt <= cmd_len - LEN_ONE;
      else if (issue_run) rem_cnt <= rem_cnt - LEN_ONE;
      vld_pipe  <= {vld_pipe[LATENCY-1:0], issue};
      last_pipe <= {last_pipe[LATENCY-1:0], issue & issue_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data <= '0;
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcnt      <= '0;
      occ       <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= ram_dout;
        fifo_last[wr_ptr] <= last_pipe[LATENCY];
        wr_ptr            <= ptr_nxt(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + OCC_ONE;
        2'b01:   fcnt <= fcnt - OCC_ONE;
        default: fcnt <= fcnt;
      endcase
      unique case ({issue, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rd_stream.sv
// Bench for bram_rd_stream: two instances (LATENCY 1 and 3, ADDR 4) share the
// clock, command fields and m_ready; each has its own RAM model and expected
// queue. Expected beats are queued when a command is accepted and compared
// at every negedge against the head while m_valid is high.
module tb_bram_rd_stream;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic        m_ready = 1;
  logic        cv [2];
  logic        rdy [2];
  logic [3:0]  ra [2];
  logic [15:0] dout [2];
  logic [15:0] md [2];
  logic        mv [2];
  logic        ml [2];
  logic        busy_s [2];

  logic [15:0] mem [16];
  logic [15:0] p3 [3];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  int n_chk = 0, n_err = 0, cyc = 0;
  int acc_cyc [2];
  bit pend [2];
  bit idle_chk [2];
  int beats [2];
  int rmode = 0, ph = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_rd_stream #(.DATA(16), .ADDR(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addr(ra[0]), .ram_dout(dout[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready), .m_last(ml[0]), .busy(busy_s[0]));

  bram_rd_stream #(.DATA(16), .ADDR(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addr(ra[1]), .ram_dout(dout[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready), .m_last(ml[1]), .busy(busy_s[1]));

  // RAM models: registered read, 1 and 3 clocks of latency.
  always @(posedge clk) begin
    dout[0] <= mem[ra[0]];
    p3[0]   <= mem[ra[1]];
    p3[1]   <= p3[0];
    p3[2]   <= p3[1];
  end
  assign dout[1] = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsz(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [16:0] qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int i, input logic [16:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [16:0] h;
        if (idle_chk[i]) begin
          chk($sformatf("idle_busy%0d", i), busy_s[i], 0);
          chk($sformatf("idle_rdy%0d", i), rdy[i], 1);
          idle_chk[i] = 0;
        end
        if (mv[i]) begin
          if (pend[i]) begin
            chk($sformatf("first_lat%0d", i), cyc - acc_cyc[i], (i == 0) ? 2 : 4);
            pend[i] = 0;
          end
          if (qsz(i) == 0) begin
            chk($sformatf("extra_beat%0d", i), mv[i], 0);
          end else begin
            h = qhead(i);
            chk($sformatf("data%0d", i), md[i], h[15:0]);
            chk($sformatf("last%0d", i), ml[i], h[16]);
            chk($sformatf("busy%0d", i), busy_s[i], 1);
            chk($sformatf("cmdrdy%0d", i), rdy[i], 0);
            if (m_ready) begin
              qpop(i);
              beats[i]++;
              if (h[16]) idle_chk[i] = 1;
            end
          end
        end
      end
    end
  end

  // m_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      1: begin m_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1;
    endcase
  end

  task automatic send(input logic [3:0] a, input logic [4:0] n);
    logic acc [2];
    int k;
    cmd_addr = a; cmd_len = n; cv[0] = 1; cv[1] = 1; k = 0;
    while ((cv[0] || cv[1]) && k < 100) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        acc[i] = cv[i] && rdy[i];
        if (acc[i]) begin
          for (int j = 0; j < int'(n); j++)
            qpush(i, {(j == int'(n) - 1), mem[4'(int'(a) + j)]});
          acc_cyc[i] = cyc + 1;
          pend[i] = (n != 0);
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          cv[i] = 0;
          if (n != 0) chk($sformatf("addr_latch%0d", i), ra[i], a);
          else begin
            chk($sformatf("len0_busy%0d", i), busy_s[i], 0);
            chk($sformatf("len0_rdy%0d", i), rdy[i], 1);
          end
        end
      end
      k++;
    end
    chk("cmd_accepted", {30'b0, cv[0], cv[1]}, 0);
    cv[0] = 0; cv[1] = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy_s[0] || busy_s[1]) && k < 600) begin
      @(negedge clk); k++;
    end
    chk("drain_done", {31'b0, k < 600}, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_rdy%0d", tag, i), rdy[i], 1);
      chk($sformatf("%s_valid%0d", tag, i), mv[i], 0);
      chk($sformatf("%s_last%0d", tag, i), ml[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), busy_s[i], 0);
      chk($sformatf("%s_addr%0d", tag, i), ra[i], 0);
      chk($sformatf("%s_data%0d", tag, i), md[i], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cv[0] = 0; cv[1] = 0;
    for (int k = 0; k < 16; k++) mem[k] = 16'hA500 + 16'(k * 17);
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; idle_chk[i] = 0; beats[i] = 0; acc_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset_vals("rst");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // basic read
    send(4'd5, 5'd4);  drain();
    // address wrap 14,15,0,1
    send(4'd14, 5'd4); drain();
    // backpressure 1,0,0,1 over a 20-word command
    rmode = 1; ph = 0;
    send(4'd7, 5'd20); drain();
    rmode = 0;
    // zero length, then single word back-to-back
    send(4'd9, 5'd0);
    send(4'd3, 5'd1);  drain();
    // a few random commands under random backpressure
    rmode = 2;
    for (int r = 0; r < 5; r++) begin
      send(4'($urandom_range(0, 15)), 5'($urandom_range(0, 24)));
      drain();
    end
    rmode = 0;

    // reset in the middle of a command
    beats[0] = 0;
    send(4'd2, 5'd16);
    for (int k = 0; k < 100 && beats[0] < 6; k++) begin @(posedge clk); #1; end
    chk("mid_beats", beats[0], 6);
    rst = 1;
    #1 reset_vals("midrst");
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin pend[i] = 0; idle_chk[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_quiet0", mv[0], 0);
    chk("post_rst_quiet1", mv[1], 0);
    @(posedge clk); #1;
    send(4'd0, 5'd2); drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
